// File: rtl/spi_minion_shift_core_if.sv
// Adapter-side push/pull bundle between the SPI shift stage and the SPI minion adapter.
// master = shift core (issues push/pull), slave = adapter (consumes push, supplies the reply).
interface spi_minion_shift_core_if #(
  parameter int nbits = 8
);
  logic             push_en;
  logic             push_msg_val_wrt;
  logic             push_msg_val_rd;
  logic [nbits-1:0] push_msg_data;
  logic             pull_en;
  logic             pull_msg_val;
  logic             pull_msg_spc;
  logic [nbits-3:0] pull_msg_data;

  modport master (
    output push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data, pull_en,
    input  pull_msg_val, pull_msg_spc, pull_msg_data
  );

  modport slave (
    input  push_en, push_msg_val_wrt, push_msg_val_rd, push_msg_data, pull_en,
    output pull_msg_val, pull_msg_spc, pull_msg_data
  );
endinterface

// File: rtl/spi_minion_shift_core.sv
// SPI mode-0 minion shift stage: synchronizes pins, shifts nbits frames in/out, and
// emits one push/pull pulse per well-formed frame (frame_err otherwise).
module spi_minion_shift_core #(
  parameter int nbits = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic frame_err,
  spi_minion_shift_core_if.master adp
);

  localparam int cw = $clog2(nbits + 2);
  localparam logic [cw-1:0] cnt_full = cw'(nbits);
  localparam logic [cw-1:0] cnt_max  = cw'(nbits + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic cs_s1, cs_s2, cs_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;
  logic cs_fall, cs_rise, sclk_rise;

  state_t           state, state_nxt;
  logic [nbits-1:0] shreg, shreg_nxt;
  logic [cw-1:0]    cnt, cnt_nxt;
  logic             eof, frame_ok;

  // cs idles high through reset so a release mid-transfer cannot fake a frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign sclk_rise = sclk_s2 & ~sclk_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    eof       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        // cs_rise wins over a coincident sclk edge: the frame is closed, not extended
        if (cs_rise) begin
          state_nxt = IDLE;
          eof       = 1'b1;
          if (cnt == cnt_full) begin
            shreg_nxt = {adp.pull_msg_val, adp.pull_msg_spc, adp.pull_msg_data};
          end else begin
            shreg_nxt = '0;
          end
        end else if (sclk_rise) begin
          shreg_nxt = {shreg[nbits-2:0], mosi_s2};
          if (cnt != cnt_max) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_ok = eof & (cnt == cnt_full);

  always_comb begin
    adp.push_en          = frame_ok;
    adp.pull_en          = frame_ok;
    adp.push_msg_val_wrt = 1'b0;
    adp.push_msg_val_rd  = 1'b0;
    adp.push_msg_data    = '0;
    frame_err            = eof & ~frame_ok;
    if (frame_ok) begin
      adp.push_msg_val_wrt = shreg[nbits-1];
      adp.push_msg_val_rd  = shreg[nbits-2];
      adp.push_msg_data    = {2'b00, shreg[nbits-3:0]};
    end
  end

  // MISO changes only after a synchronized sclk rise, i.e. well after the host sampled it
  assign spi_miso = shreg[nbits-1];

endmodule

// File: tb/tb_spi_minion_shift_core.sv
// Scoreboarded bench for spi_minion_shift_core: expected pushes queued at stimulus time,
// popped by a negedge monitor; MISO bits checked against a reply model.
module tb_spi_minion_shift_core;

  localparam int nbits = 8;

  typedef struct packed {
    logic       wrt;
    logic       rd;
    logic [7:0] data;
  } push_t;

  logic clk = 1'b0;
  logic reset;
  logic spi_cs, spi_sclk, spi_mosi, spi_miso, frame_err;

  spi_minion_shift_core_if #(.nbits(nbits)) adp ();

  spi_minion_shift_core #(.nbits(nbits)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .frame_err (frame_err),
    .adp       (adp)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  push_t exp_q[$];
  int    push_seen = 0;
  int    err_seen  = 0;
  int    push_exp  = 0;
  int    err_exp   = 0;
  logic [7:0] reply_model = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every push must match the head of the scoreboard; idle cycles must be quiet
  always @(negedge clk) begin
    if (adp.push_en === 1'b1) begin
      push_t e;
      push_seen++;
      check_eq("pull_with_push", {31'd0, adp.pull_en}, 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("push_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("push_val_wrt", {31'd0, adp.push_msg_val_wrt}, {31'd0, e.wrt});
        check_eq("push_val_rd", {31'd0, adp.push_msg_val_rd}, {31'd0, e.rd});
        check_eq("push_data", {24'd0, adp.push_msg_data}, {24'd0, e.data});
      end
    end else begin
      check_eq("pull_idle", {31'd0, adp.pull_en}, 32'd0);
      check_eq("push_fields_idle",
               {22'd0, adp.push_msg_val_wrt, adp.push_msg_val_rd, adp.push_msg_data}, 32'd0);
    end
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_reply(input logic val, input logic spc, input logic [5:0] data);
    adp.pull_msg_val  = val;
    adp.pull_msg_spc  = spc;
    adp.pull_msg_data = data;
  endtask

  // Host side of one mode-0 transfer; bits beyond the eighth are not compared on MISO
  task automatic spi_edges(input int nedges, input logic [7:0] mosi_v, input logic [7:0] miso_exp);
    logic [7:0] mv;
    mv = mosi_v;
    for (int i = 0; i < nedges; i++) begin
      spi_mosi = (i < 8) ? mv[7-i] : 1'b0;
      tick(8);
      if (i < 8) check_eq($sformatf("miso_bit%0d", i), {31'd0, spi_miso}, {31'd0, miso_exp[7-i]});
      spi_sclk = 1'b1;
      tick(8);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int nedges, input logic [7:0] mosi_v);
    logic [7:0] rep;
    push_t p;
    spi_cs = 1'b0;
    tick(8);
    spi_edges(nedges, mosi_v, reply_model);
    if (nedges == 8) begin
      p.wrt  = mosi_v[7];
      p.rd   = mosi_v[6];
      p.data = {2'b00, mosi_v[5:0]};
      exp_q.push_back(p);
      push_exp++;
      rep = {adp.pull_msg_val, adp.pull_msg_spc, adp.pull_msg_data};
      reply_model = rep;
    end else begin
      err_exp++;
      reply_model = 8'h00;
    end
    tick(8);
    spi_cs = 1'b1;
    tick(12);
    check_eq("push_count", push_seen, push_exp);
    check_eq("err_count", err_seen, err_exp);
  endtask

  initial begin
    reset    = 1'b1;
    spi_cs   = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    set_reply(1'b0, 1'b0, 6'h00);
    tick(5);
    check_eq("rst_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("rst_push_en", {31'd0, adp.push_en}, 32'd0);
    check_eq("rst_pull_en", {31'd0, adp.pull_en}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    tick(20);
    check_eq("idle_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("idle_push_count", push_seen, 0);
    check_eq("idle_err_count", err_seen, 0);

    // write 0x2A, reply = {val0, spc1, 0}
    set_reply(1'b0, 1'b1, 6'h00);
    spi_frame(8, 8'b10_101010);

    // read request, reply = {1,1,0x15} -> 0xD5
    set_reply(1'b1, 1'b1, 6'h15);
    spi_frame(8, 8'b01_000000);

    // short frame: first five bits of 0xD5 on MISO, then frame_err and a cleared reply
    spi_frame(5, 8'b11111000);

    // interrupted frame: MISO must read 0 after the short frame; reset kills it
    spi_cs = 1'b0;
    tick(8);
    spi_edges(4, 8'b1010_0000, 8'h00);
    reset = 1'b1;
    tick(4);
    spi_cs = 1'b1;
    tick(10);
    reset = 1'b0;
    reply_model = 8'h00;
    tick(12);
    check_eq("rst_mid_push_count", push_seen, push_exp);
    check_eq("rst_mid_err_count", err_seen, err_exp);
    check_eq("rst_mid_miso", {31'd0, spi_miso}, 32'd0);

    set_reply(1'b1, 1'b0, 6'h2B);
    spi_frame(8, 8'b10_000111);

    // sclk activity with cs high must not shift or count
    for (int i = 0; i < 6; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      spi_sclk = 1'b1;
      tick(8);
      spi_sclk = 1'b0;
      tick(8);
    end
    check_eq("idle_sclk_miso", {31'd0, spi_miso}, {31'd0, reply_model[7]});
    set_reply(1'b0, 1'b1, 6'h3C);
    spi_frame(8, 8'b11_111111);

    // long frame: ten edges -> frame_err, reply cleared
    spi_frame(10, 8'b0110_0110);

    set_reply(1'b1, 1'b1, 6'h01);
    spi_frame(8, 8'b01_010101);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_minion_shift_core.md
Name: spi_minion_shift_core

Overview:
SPI minion physical/shift stage that sits directly upstream of the SPI minion adapter.
- Synchronizes the external SPI pins (mode 0, CS active-low) into the system clock domain.
- Shifts an nbits-wide frame in on MOSI and out on MISO.
- At the end of each frame, issues one simultaneous push/pull pulse to the adapter.
- The reply loaded by the pull is shifted out during the *next* frame.

Parameters:
nbits, 8, frame width in bits; bit nbits-1 = write-valid flag, bit nbits-2 = read-valid flag, bits nbits-3:0 = payload.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
spi_cs  input  1  chip select from SPI host, active-low, asynchronous to clk
spi_sclk  input  1  SPI clock from host, asynchronous to clk
spi_mosi  input  1  serial data from host
spi_miso  output  1  serial data to host; always the MSB of the shift register
push_en  output  1  one-cycle pulse at a valid end of frame
push_msg_val_wrt  output  1  frame bit nbits-1, valid while push_en=1
push_msg_val_rd  output  1  frame bit nbits-2, valid while push_en=1
push_msg_data  output  nbits  {2'b00, frame bits nbits-3:0}, valid while push_en=1
pull_en  output  1  one-cycle pulse, same cycle as push_en
pull_msg_val  input  1  reply-valid from adapter; sampled while pull_en=1
pull_msg_spc  input  1  space-available from adapter; sampled while pull_en=1
pull_msg_data  input  nbits-2  reply payload; sampled while pull_en=1
frame_err  output  1  one-cycle pulse when a frame ends with a bit count other than nbits

Behaviour:
- Reset (asynchronous, active-high):
  - cs synchronizer stages reset to 1.
  - sclk and mosi synchronizer stages reset to 0.
  - Shift register, bit counter and spi_miso reset to 0.
  - push_en, pull_en and frame_err are 0.
  - Reset asserted mid-frame discards the frame. After release, a cs rising edge produces no pulse, because the cs synchronizer already reads 1.
- Synchronization:
  - cs, sclk and mosi each pass through a 2-flop synchronizer (s1, s2), plus a third flop s3 for edge detection.
  - cs_fall = ~cs_s2 & cs_s3; cs_rise = cs_s2 & ~cs_s3; sclk_rise = sclk_s2 & ~sclk_s3.
  - A pin change sampled at clk edge k appears as an edge event in the cycle following edge k+1.
- States: IDLE (cs_s2=1), ACTIVE (cs_s2=0).
  - cs_fall: IDLE -> ACTIVE; bit counter cleared to 0; shift register unchanged, so the pending reply is already on spi_miso.
- Shift, on sclk_rise while ACTIVE:
  - shreg <= {shreg[nbits-2:0], mosi_s2}.
  - Counter increments, saturating at nbits+1.
  - spi_miso follows shreg[nbits-1], so it updates after the host's rising-edge sample, as mode 0 requires.
  - sclk edges in IDLE are ignored.
- End of frame, cs_rise, ACTIVE -> IDLE:
  - Counter == nbits:
    - push_en=1 and pull_en=1 combinationally for exactly that cycle.
    - push fields are taken from the current shreg.
    - At the closing clk edge: shreg <= {pull_msg_val, pull_msg_spc, pull_msg_data}.
  - Counter != nbits (short or long frame):
    - push_en=pull_en=0; frame_err=1 for one cycle.
    - shreg cleared to 0, so the host reads 0 on the next frame.
- Simultaneous sclk_rise and cs_rise in the same cycle: cs_rise takes priority and the sclk edge is not shifted.
- Outside a push_en cycle, push_msg_* outputs are 0. pull_* inputs are ignored unless pull_en=1.
- Throughput: one frame per CS assertion. Minimum sclk period is 3 clk periods high and 3 low; faster sclk is out of spec and may produce frame_err.

Test Plan:
- All cases use nbits=8, sclk = 8 clk high / 8 clk low.
- Reset, then idle 20 cycles -> spi_miso=0; push_en, pull_en, frame_err never pulse.
- Frame MOSI=0b10_101010 (write 0x2A); adapter drives pull_msg_val=0, spc=1, data=0 -> single push_en cycle with val_wrt=1, val_rd=0, push_msg_data=0x2A; pull_en in the same cycle; next frame MISO = 0b01_000000.
- Frame 0b01_000000 (read request) with adapter replying val=1, spc=1, data=0x15 at pull_en -> next frame MISO bits, MSB first = 1,1,0,1,0,1,0,1 (0xD5); push_msg_val_rd=1, val_wrt=0.
- Short frame of 5 sclk edges, then CS high -> frame_err pulses once, no push_en/pull_en; next frame MISO = 0x00.
- Reset asserted after 4 sclk edges, released, then a full 8-bit frame 0b10_000111 -> the first CS rise produces no pulse; the second frame pushes data 0x07.
- sclk toggling while CS high, followed by a valid frame 0b11_111111 -> idle edges ignored; push val_wrt=1, val_rd=1, data=0x3F.
